// File: rtl/dat_mem_stk.sv
// dat_mem_stk: DW x 2**AW data memory with a random load/store port and a downward-growing stack; define DAT_MEM_CLR_EN for the post-reset zeroing sequencer
module dat_mem_stk #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic [AW-1:0] sp,
  output logic          full,
  output logic          empty,
  output logic          ready,
  output logic [2:0]    err,
  input  logic          err_clr
);
  localparam int N = 2**AW;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;
  logic [DW-1:0] core [N];
  logic [AW:0] cnt;
  logic [AW-1:0] top, stk_wa, mem_wa;
  logic [DW-1:0] mem_wd;
  logic run, stk_we, inc, dec, mem_we;
  logic [2:0] err_set;
  assign run     = state == RUN;
  assign ready   = run;
  assign empty   = cnt == '0;
  assign full    = cnt[AW];
  // (N-1-cnt) mod N is the bitwise inverse; the top word sits one above it
  assign sp      = ~cnt[AW-1:0];
  assign top     = sp + 1'b1;
  assign pop_dat = empty ? '0 : core[top];
  assign dat_out = core[addr];
  assign stk_we  = run & push & (pop | ~full);
  assign stk_wa  = (pop & ~empty) ? top : sp;
  assign inc     = run & push & ~full & (~pop | empty);
  assign dec     = run & pop & ~push & ~empty;
  assign err_set = run ? {wr_en & stk_we, pop & ~push & empty, push & ~pop & full} : 3'b000;
`ifdef DAT_MEM_CLR_EN
  logic [AW-1:0] cp;
  logic clearing;
  assign clearing = state == CLEAR;
  assign mem_we   = clearing | stk_we | (run & wr_en);
  assign mem_wa   = clearing ? cp : stk_we ? stk_wa : addr;
  assign mem_wd   = clearing ? '0 : stk_we ? push_dat : dat_in;
  always_comb begin
    state_nxt = (clearing && &cp) ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) cp <= '0;
    else if (clearing) cp <= cp + 1'b1;
  end
`else
  assign mem_we = stk_we | (run & wr_en);
  assign mem_wa = stk_we ? stk_wa : addr;
  assign mem_wd = stk_we ? push_dat : dat_in;
  always_comb begin
    state_nxt = RUN;
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) state <= CLEAR;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) cnt <= '0;
    else cnt <= inc ? cnt + 1'b1 : dec ? cnt - 1'b1 : cnt;
  end
  // a set event in the same cycle as err_clr survives the clear
  always_ff @(posedge clk) begin
    if (!reset_n) err <= '0;
    else err <= (err_clr ? 3'b000 : err) | err_set;
  end
  always_ff @(posedge clk) begin
    if (mem_we) core[mem_wa] <= mem_wd;
  end
endmodule

// File: tb/tb_dat_mem_stk.sv
// tb_dat_mem_stk: random and directed stimulus against a behavioural memory/stack model
module tb_dat_mem_stk;
`ifdef DAT_MEM_CLR_EN
  localparam int LAT = 256;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, reset_n, wr_en, push, pop, err_clr, full, empty, ready;
  logic [7:0] addr, dat_in, dat_out, push_dat, pop_dat, sp;
  logic [2:0] err;
  int n_cmp = 0, n_bad = 0;
  int m_cnt = 0, m_cp = 0;
  logic [7:0] m_mem [256];
  bit m_kn [256];
  logic [2:0] m_err = 0;
  bit m_ready = 0;

  dat_mem_stk dut (.clk(clk), .reset_n(reset_n), .wr_en(wr_en), .addr(addr), .dat_in(dat_in),
    .dat_out(dat_out), .push(push), .push_dat(push_dat), .pop(pop), .pop_dat(pop_dat), .sp(sp),
    .full(full), .empty(empty), .ready(ready), .err(err), .err_clr(err_clr));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int tp, sp_i, swa;
    bit fl, em, swe;
    logic [2:0] ne;
    if (!reset_n) begin
      m_cnt = 0; m_err = 0; m_ready = 0; m_cp = 0;
      return;
    end
    if (!m_ready) begin
      if (err_clr) m_err = 0;
`ifdef DAT_MEM_CLR_EN
      m_mem[m_cp] = 0; m_kn[m_cp] = 1; m_cp++;
      if (m_cp == 256) m_ready = 1;
`else
      m_ready = 1;
`endif
      return;
    end
    fl = m_cnt == 256; em = m_cnt == 0;
    sp_i = (255 - m_cnt) & 255; tp = (256 - m_cnt) & 255;
    ne = err_clr ? 3'b000 : m_err;
    swe = 0; swa = 0;
    if (push && pop && !em) begin swe = 1; swa = tp; end
    else if (push) begin
      if (fl) ne[0] = 1;
      else begin swe = 1; swa = sp_i; m_cnt++; end
    end else if (pop) begin
      if (em) ne[1] = 1;
      else m_cnt--;
    end
    if (swe) begin m_mem[swa] = push_dat; m_kn[swa] = 1; end
    if (wr_en) begin
      if (swe) ne[2] = 1;
      else begin m_mem[addr] = dat_in; m_kn[addr] = 1; end
    end
    m_err = ne;
  endtask

  task automatic check_all();
    int tp;
    chk("ready", ready, m_ready);
    chk("empty", empty, m_cnt == 0);
    chk("full", full, m_cnt == 256);
    chk("sp", sp, (255 - m_cnt) & 255);
    chk("err", err, m_err);
    tp = (256 - m_cnt) & 255;
    if (m_cnt == 0) chk("pop_dat", pop_dat, 0);
    else if (m_kn[tp]) chk("pop_dat", pop_dat, m_mem[tp]);
    if (m_kn[addr]) chk("dat_out", dat_out, m_mem[addr]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    wr_en = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    reset_n = 1;
    while (!ready && n < 1000) begin tick(); n++; end
    chk("rdy_lat", n, LAT);
  endtask

  initial begin
    int bias;
    idle(); addr = 0; dat_in = 0; push_dat = 0; reset_n = 0;
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_sp", sp, 8'hff);
    chk("rst_err", err, 0);
    chk("rst_pop", pop_dat, 0);
    wait_ready();
`ifdef DAT_MEM_CLR_EN
    for (int a = 0; a < 256; a++) begin
      addr = 8'(a); #2;
      chk("clr_zero", dat_out, 0);
      tick();
    end
`endif
    for (int a = 0; a < 256; a++) begin
      wr_en = 1; addr = 8'(a); dat_in = 8'($urandom);
      tick();
    end
    idle();
    push = 1; push_dat = 8'h11; tick();
    push_dat = 8'h22; tick();
    push_dat = 8'h33; tick();
    idle(); addr = 8'hfe; #2;
    chk("sp3", sp, 8'hfc);
    chk("top3", pop_dat, 8'h33);
    chk("rd_fe", dat_out, 8'h22);
    pop = 1; tick();
    chk("pop1", pop_dat, 8'h22);
    tick();
    chk("pop2", pop_dat, 8'h11);
    tick();
    chk("pop3_empty", empty, 1);
    chk("pop3_dat", pop_dat, 0);
    idle(); push = 1;
    for (int i = 0; i < 256; i++) begin push_dat = 8'($urandom); tick(); end
    chk("fill_full", full, 1);
    chk("fill_sp", sp, 8'hff);
    tick();
    chk("ovf_err", err, 3'b001);
    chk("ovf_full", full, 1);
    idle(); pop = 1;
    repeat (256) tick();
    tick();
    chk("unf_err", err, 3'b011);
    idle(); err_clr = 1; tick();
    chk("clr_err", err, 0);
    idle(); push = 1; push_dat = 8'h33; tick();
    pop = 1; push_dat = 8'h44; tick();
    chk("rep_dat", pop_dat, 8'h44);
    chk("rep_sp", sp, 8'hfe);
    idle(); pop = 1; tick();
    push = 1; push_dat = 8'h55; tick();
    chk("pp_empty_sp", sp, 8'hfe);
    chk("pp_empty_err", err, 0);
    chk("pp_empty_dat", pop_dat, 8'h55);
    idle(); wr_en = 1; addr = 8'h10; dat_in = 8'h00; tick();
    dat_in = 8'haa; push = 1; push_dat = 8'h77; tick();
    idle(); addr = 8'h10; #2;
    chk("cfl_mem", dat_out, 8'h00);
    chk("cfl_err", err, 3'b100);
    chk("cfl_top", pop_dat, 8'h77);
    err_clr = 1; tick();
    idle(); wr_en = 1; addr = 8'h10; dat_in = 8'haa; pop = 1; tick();
    idle(); addr = 8'h10; #2;
    chk("wr_pop_mem", dat_out, 8'haa);
    chk("wr_pop_err", err, 0);
    bias = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) bias = ($urandom_range(0, 2) == 0) ? 15 : ($urandom_range(0, 1) == 0) ? 50 : 85;
      if ($urandom_range(0, 999) == 0) begin
        idle(); reset_n = 0; tick(); wait_ready();
      end
      push = $urandom_range(0, 99) < bias;
      pop = $urandom_range(0, 99) < 100 - bias;
      wr_en = $urandom_range(0, 3) == 0;
      err_clr = $urandom_range(0, 15) == 0;
      addr = 8'($urandom); dat_in = 8'($urandom); push_dat = 8'($urandom);
      tick();
    end
    idle(); reset_n = 0; tick(); wait_ready();
    push = 1;
    for (int i = 0; i < 5; i++) begin push_dat = 8'($urandom_range(1, 255)); tick(); end
    idle(); reset_n = 0; tick();
    chk("mid_ready", ready, 0);
    chk("mid_empty", empty, 1);
    chk("mid_sp", sp, 8'hff);
    wait_ready();
`ifdef DAT_MEM_CLR_EN
    for (int a = 251; a < 256; a++) begin
      addr = 8'(a); #2;
      chk("mid_clr", dat_out, 0);
      tick();
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
